q_sys_result_fifo: RTL and testbench

Buffers 32-bit results from the error-correcting arithmetic datapath and presents them, one word at a time, to the Qsys data input PIO (`in_port`) for Nios software to read. It sits directly upstream of the data input port. Software consumes each word and then advances the queue with a pop strobe from a control output PIO. It also publishes a status word, with count, empty/full and sticky error flags, to a second input PIO.

---
 rtl/q_sys_result_pkg.sv | 18 +
 rtl/q_sys_result_fifo_if.sv | 22 ++
 rtl/q_sys_rise_detect.sv | 21 ++
 rtl/q_sys_result_fifo.sv | 102 ++++++++++
 tb/tb_q_sys_result_fifo.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/q_sys_result_pkg.sv
// Shared constants for the result FIFO: status word bit map, default depth
// and pointer-width helper.
package q_sys_result_pkg;

    localparam int DEFAULT_DEPTH = 16;

    localparam int ST_CNT_LSB = 0;
    localparam int ST_CNT_W   = 6;
    localparam int ST_EMPTY   = 8;
    localparam int ST_FULL    = 9;
    localparam int ST_OVF     = 16;
    localparam int ST_UNF     = 17;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/q_sys_result_fifo_if.sv
// Result stream plus PIO-facing control/readback signals of the result FIFO.
interface q_sys_result_fifo_if #(
    parameter int DATA_W = 32
);
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              pop_req;
    logic              clear_req;
    logic [DATA_W-1:0] data_out;
    logic [31:0]       status_out;

    modport master (
        output res_valid, res_data, pop_req, clear_req,
        input  res_ready, data_out, status_out
    );

    modport slave (
        input  res_valid, res_data, pop_req, clear_req,
        output res_ready, data_out, status_out
    );
endinterface

// File: rtl/q_sys_rise_detect.sv
// Registers a level from a control PIO and emits a one-cycle pulse on its
// rising edge.
module q_sys_rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic pulse
);
    logic sig_q, sig_d;

    always_comb begin
        sig_d = sig_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sig_q <= 1'b0;
        else       sig_q <= sig_d;
    end

    assign pulse = sig_in & ~sig_q;
endmodule

// File: rtl/q_sys_result_fifo.sv
// Result FIFO between the arithmetic datapath and the Nios data/status PIOs.
// Head word and status are registered from next-state values so they agree.
module q_sys_result_fifo
    import q_sys_result_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    q_sys_result_fifo_if.slave  bus
);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic pop_pulse, clr_pulse;

    q_sys_rise_detect u_pop_det (.clk(clk), .reset(reset), .sig_in(bus.pop_req),   .pulse(pop_pulse));
    q_sys_rise_detect u_clr_det (.clk(clk), .reset(reset), .sig_in(bus.clear_req), .pulse(clr_pulse));

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [31:0]       status_q, status_d;
    logic              full, push, do_pop;

    assign full          = (count_q == CNT_W'(DEPTH));
    assign bus.res_ready = ~full & ~clr_pulse;
    assign push          = bus.res_valid & bus.res_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        do_pop   = 1'b0;
        if (clr_pulse) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (bus.res_valid && full) ovf_d = 1'b1;
            // A pop into an empty FIFO is refused even if a push lands this cycle.
            if (pop_pulse) begin
                if (count_q == '0) begin
                    unf_d = 1'b1;
                end else begin
                    do_pop   = 1'b1;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(do_pop);
        end

        // New head may be the word being written this cycle (empty, or pop down to it).
        data_d = '0;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) data_d = bus.res_data;
            else                                data_d = mem_q[rd_ptr_d];
        end

        status_d                          = '0;
        status_d[ST_CNT_LSB +: CNT_W]     = count_d;
        status_d[ST_EMPTY]                = (count_d == '0);
        status_d[ST_FULL]                 = (count_d == CNT_W'(DEPTH));
        status_d[ST_OVF]                  = ovf_d;
        status_d[ST_UNF]                  = unf_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            data_q   <= '0;
            status_q <= 32'h0000_0100;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.res_data;
    end

    assign bus.data_out   = data_q;
    assign bus.status_out = status_q;
endmodule

// File: tb/tb_q_sys_result_fifo.sv
// Directed plus randomized bench for q_sys_result_fifo against a queue model.
module tb_q_sys_result_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    q_sys_result_fifo_if #(.DATA_W(32)) bus ();

    q_sys_result_fifo #(.DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mq [$];
    logic        m_ovf, m_unf, prev_pop, prev_clr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'(mq.size());
        s[8]  = (mq.size() == 0);
        s[9]  = (mq.size() == DEPTH);
        s[16] = m_ovf;
        s[17] = m_unf;
        return s;
    endfunction

    function automatic logic [31:0] exp_data();
        return (mq.size() == 0) ? 32'h0 : mq[0];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0; m_unf = 1'b0; prev_pop = 1'b0; prev_clr = 1'b0;
    endtask

    // Entered and left at posedge+1; checks ready before the edge, outputs after.
    task automatic cycle(input logic v, input logic [31:0] d, input logic p, input logic c);
        logic pe, ce, was_full;
        bus.res_valid = v; bus.res_data = d; bus.pop_req = p; bus.clear_req = c;
        pe = p & ~prev_pop;
        ce = c & ~prev_clr;
        was_full = (mq.size() == DEPTH);
        #1 chk("res_ready", 32'(bus.res_ready), 32'(!was_full && !ce));
        @(posedge clk);
        if (ce) begin
            mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (v && was_full) m_ovf = 1'b1;
            if (pe) begin
                if (mq.size() == 0) m_unf = 1'b1;
                else                void'(mq.pop_front());
            end
            if (v && !was_full) mq.push_back(d);
        end
        prev_pop = p; prev_clr = c;
        #1;
        chk("data_out", bus.data_out, exp_data());
        chk("status_out", bus.status_out, exp_status());
    endtask

    task automatic pop_once();
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        bus.res_valid = 1'b0; bus.res_data = '0; bus.pop_req = 1'b0; bus.clear_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("rst_data", bus.data_out, 32'h0);
        chk("rst_status", bus.status_out, 32'h0000_0100);
        chk("rst_ready", 32'(bus.res_ready), 32'h1);
        @(posedge clk); #1;

        // Three fixed words then three pops
        cycle(1'b1, 32'h1111_1111, 1'b0, 1'b0);
        cycle(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        cycle(1'b1, 32'h3333_3333, 1'b0, 1'b0);
        chk("three_head", bus.data_out, 32'h1111_1111);
        chk("three_status", bus.status_out, 32'h0000_0003);
        repeat (3) pop_once();
        chk("three_drained", bus.status_out, 32'h0000_0100);

        // Fill to full, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        chk("full_status", bus.status_out, 32'h0000_0210);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("ovf_status", bus.status_out, 32'h0001_0210);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) pop_once();

        // Underflow then clear
        pop_once();
        chk("unf_status", bus.status_out, 32'h0003_0100);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("clr_status", bus.status_out, 32'h0000_0100);

        // Pop with push into empty: push kept, underflow set
        cycle(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);

        // Steady count=2 with push+pop across pointer wrap
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, $urandom, 1'b1, 1'b0);
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
        end
        chk("steady_cnt2", bus.status_out, 32'h0000_0002);

        // Held pop pops once
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("held_pop_cnt", bus.status_out, 32'h0000_0002);

        // Randomized fill-heavy then drain-heavy traffic
        for (int i = 0; i < 300; i++) begin
            int vp;
            vp = (i < 150) ? 80 : 20;
            cycle($urandom_range(0, 99) < vp, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 99) < 2);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        bus.res_valid = 1'b0; bus.pop_req = 1'b0; bus.clear_req = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("async_rst_data", bus.data_out, 32'h0);
        chk("async_rst_status", bus.status_out, 32'h0000_0100);
        chk("async_rst_ready", 32'(bus.res_ready), 32'h1);
        model_reset();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        cycle(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        chk("post_rst_head", bus.data_out, 32'h0BAD_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
